// File: rtl/sram_like_responder_if.sv
// sram-like request/response bundle between a master (fetch/memory stage) and a responder.
//   req/wr/size/addr/wstrb/wdata : request, driven by the master
//   addr_ok                      : request accepted when req && addr_ok
//   data_ok/rdata                : one-cycle in-order response pulse with read data
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// Responder end of the sram-like bus. Accepted requests are issued to a synchronous single-port
// word RAM in the accept cycle and answered in acceptance order, no earlier than DATA_LAT cycles
// after acceptance, with at most DEPTH requests outstanding.
//   clk, resetn          : clock (posedge), asynchronous active-low reset
//   bus (slave)          : sram-like request/response signals
//   addr_stall           : forces addr_ok low
//   data_stall           : forces data_ok low (latency timers keep running)
//   ram_en/ram_we        : RAM access enable, byte write enables (0 for reads)
//   ram_addr/ram_wdata   : RAM word address and write data
//   ram_rdata            : RAM read data, valid the cycle after a read access
module sram_like_responder #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned DATA_LAT = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_like_responder_if.slave  bus,
    input  logic                  addr_stall,
    input  logic                  data_stall,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [3:0]       LAT_C    = 4'(DATA_LAT);

    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    // A read accepted last cycle whose RAM data is on ram_rdata this cycle.
    logic             cap_q;
    logic [PTR_W-1:0] cap_ptr_q;

    logic             is_wr_q [DEPTH];
    logic [3:0]       age_q   [DEPTH];
    logic [31:0]      data_q  [DEPTH];

    logic accept;
    logic head_elig;
    logic fwd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Only count, the stall hook and reset: the master builds req from addr_ok.
    assign bus.addr_ok = resetn && (count_q < DEPTH_C) && !addr_stall;
    assign accept      = bus.req && bus.addr_ok;
    assign head_elig   = (count_q != '0) && (age_q[rd_ptr_q] >= LAT_C);
    assign bus.data_ok = head_elig && !data_stall;
    // Head read whose RAM data arrives this very cycle has not been captured yet.
    assign fwd         = cap_q && (cap_ptr_q == rd_ptr_q);

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.data_ok && !is_wr_q[rd_ptr_q]) begin
            bus.rdata = fwd ? ram_rdata : data_q[rd_ptr_q];
        end
    end

    always_comb begin
        ram_en    = accept;
        ram_we    = (accept && bus.wr) ? bus.wstrb : 4'h0;
        ram_addr  = bus.addr[ADDR_W+1:2];
        ram_wdata = bus.wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cap_q     <= 1'b0;
            cap_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                is_wr_q[i] <= 1'b0;
                age_q[i]   <= 4'h0;
                data_q[i]  <= 32'h0;
            end
        end else begin
            // Timers run for every slot regardless of head position or data_stall.
            for (int i = 0; i < DEPTH; i++) begin
                if (age_q[i] < LAT_C) begin
                    age_q[i] <= age_q[i] + 4'h1;
                end
            end

            if (cap_q) begin
                data_q[cap_ptr_q] <= ram_rdata;
            end

            if (accept) begin
                is_wr_q[wr_ptr_q] <= bus.wr;
                age_q[wr_ptr_q]   <= 4'h1;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            cap_q     <= accept && !bus.wr;
            cap_ptr_q <= wr_ptr_q;

            if (bus.data_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            case ({accept, bus.data_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // size and the address bits outside the RAM word index are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Slave/responder end of the sram-like interface that the fetch and memory stages drive (req/wr/size/addr/wstrb/wdata out; addr_ok/data_ok/rdata back).
- Accepts requests, performs them on a synchronous single-port word RAM, and returns in-order responses with configurable minimum latency, configurable outstanding depth, and injectable stalls.
- Serves as the inst/data sram-like target in SoC-lite and as the CPU-side test model.

Parameters:
DEPTH, 2, max outstanding accepted-but-unanswered requests (1..8)
DATA_LAT, 1, minimum cycles from accept to data_ok (1..15)
ADDR_W, 16, RAM word-address width

Ports:
clk  in  1  clock, all logic on posedge
resetn  in  1  asynchronous active-low reset
req  in  1  master request valid
wr  in  1  1 = write, 0 = read
size  in  2  transfer size (0 = byte, 1 = half, 2 = word); informational only, wstrb is authoritative
addr  in  32  byte address; addr[ADDR_W+1:2] selects RAM word, other bits ignored
wstrb  in  4  write byte enables
wdata  in  32  write data
addr_ok  out  1  request accepted this cycle when req && addr_ok
data_ok  out  1  one-cycle response pulse for the oldest outstanding request
rdata  out  32  read data, valid when data_ok
addr_stall  in  1  test hook: forces addr_ok low
data_stall  in  1  test hook: forces data_ok low
ram_en  out  1  RAM access enable
ram_we  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we == 0

Behaviour:
- Reset (resetn low, async): outstanding count = 0, all queue entries invalid; addr_ok = 0, data_ok = 0, rdata = 0, ram_en = 0, ram_we = 0.
- addr_ok = (count < DEPTH) && !addr_stall && resetn.
  - addr_ok must not depend combinationally on req, wr, addr or any other request input, because the master derives req from addr_ok.
- Accept at cycle t (req && addr_ok):
  - Same cycle: ram_en = 1, ram_addr = addr[ADDR_W+1:2], ram_wdata = wdata.
  - ram_we = wr ? wstrb : 4'h0.
  - A queue entry is pushed, tagged read or write.
  - When not accepting, ram_en = 0 and ram_we = 0.
- Read data capture: ram_rdata is sampled into the entry at cycle t+1.
  - If that entry answers in cycle t+1 (DATA_LAT = 1), rdata forwards ram_rdata directly.
- Response rules:
  - The head entry becomes eligible from cycle t+DATA_LAT onward.
  - data_ok = head valid && eligible && !data_stall.
  - On data_ok the head is popped; at most one response per cycle.
  - Responses are strictly in acceptance order.
  - Writes also return data_ok, with rdata = 0.
  - rdata = 0 whenever data_ok = 0.
  - data_ok has no ready back-pressure: the master must take it.
- Latency counting: eligibility timers keep running during data_stall and while an entry is not at head.
  - Back-to-back entries therefore answer on consecutive cycles once eligible.
- Count:
  - +1 on accept, -1 on data_ok, unchanged on both in the same cycle.
  - Full (count == DEPTH) lowers addr_ok. A data_ok in the same cycle does not free a slot for that cycle's accept; the slot is freed next cycle.
- Simultaneous accept and data_ok: both take effect, including when count == DEPTH-1 or when the queue holds one entry being popped.
- Queue pointers wrap modulo DEPTH. With DEPTH = 1 the block alternates accept/answer.
- No cancel input: every accepted request is always answered, even if the master discards it (e.g., after an exception flush). The master counts outstanding requests itself.
- Reset mid-operation: all outstanding requests are dropped silently, and no data_ok is issued after resetn is released for requests accepted before reset.
- Read-after-write to the same word accepted on consecutive cycles returns the new data (RAM is write-then-read ordered by issue cycle).

Test Plan:
- DEPTH=2, DATA_LAT=1, no stalls: write 0x12345678 (wstrb 4'hF) to 0x00000010, then read 0x00000010 -> write data_ok at t+1 with rdata 0; read data_ok at t+2 with rdata 0x12345678.
- Byte write wstrb 4'h2, wdata 0x0000AB00 onto a word holding 0x11223344, then read -> rdata 0x1122AB44.
- Hold req high for 6 reads, DATA_LAT=3, DEPTH=2 -> addr_ok low whenever count == 2; data_ok in acceptance order with correct per-address data; never more than 2 outstanding.
- data_stall high for 5 cycles with 2 eligible entries -> no data_ok during the stall; data_ok on the 2 consecutive cycles after release; addr_ok stays 0 while full.
- addr_stall pulsed with req held -> no ram_en or accept while stalled; addr_ok never toggles in response to req changes (check combinational independence by toggling req alone).
- resetn asserted low with 2 reads outstanding -> data_ok/addr_ok go 0 immediately (async); after release, addr_ok = 1 next cycle and no stale data_ok appears.
